// File: rtl/ram_port_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | ram_port_arbiter_if : client A/B request buses plus RAM-side port bundle    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  logic                  req_a;
  logic                  we_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] din_a;
  logic                  gnt_a;
  logic                  rvalid_a;

  logic                  req_b;
  logic                  we_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] din_b;
  logic                  gnt_b;
  logic                  rvalid_b;

  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  // Clients and the RAM instance together form the master side.
  modport master (
    output req_a, we_a, addr_a, din_a,
    output req_b, we_b, addr_b, din_b,
    output ram_dout,
    input  gnt_a, rvalid_a, gnt_b, rvalid_b, rdata, busy,
    input  ram_we, ram_addr, ram_din
  );

  modport slave (
    input  req_a, we_a, addr_a, din_a,
    input  req_b, we_b, addr_b, din_b,
    input  ram_dout,
    output gnt_a, rvalid_a, gnt_b, rvalid_b, rdata, busy,
    output ram_we, ram_addr, ram_din
  );
endinterface

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | ram_port_arbiter : round-robin A/B sharing of one sync-read single-port RAM |
// | Optional post-reset RAM clear enabled by macro RAM_ARB_INIT_EN              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  ram_port_arbiter_if.slave bus
);

  logic                  w_run;
  logic                  w_sel_a;
  logic                  w_sel_b;
  logic                  w_gnt_a;
  logic                  w_gnt_b;
  logic [ADDR_WIDTH-1:0] w_init_addr;
  logic                  r_last_b;
  logic                  r_rvalid_a;
  logic                  r_rvalid_b;

`ifdef RAM_ARB_INIT_EN
  localparam logic [0:0]            c_st_init = 1'b0;
  localparam logic [0:0]            c_st_run  = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] c_one     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_init_cnt;

  // Clear sweep: one address per cycle, leave INIT once the last address is written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= c_st_init;
      r_init_cnt <= '0;
    end else if (r_state == c_st_init) begin
      r_init_cnt <= r_init_cnt + c_one;
      if (&r_init_cnt) begin
        r_state <= c_st_run;
      end
    end
  end

  assign w_run       = (r_state == c_st_run);
  assign w_init_addr = r_init_cnt;
  assign bus.busy    = (r_state == c_st_init);
`else
  assign w_run       = 1'b1;
  assign w_init_addr = '0;
  assign bus.busy    = 1'b0;
`endif

  // Ties go to whichever client was not served most recently.
  assign w_sel_a = bus.req_a & (~bus.req_b | r_last_b);
  assign w_sel_b = bus.req_b & (~bus.req_a | ~r_last_b);
  assign w_gnt_a = reset_n & w_run & w_sel_a;
  assign w_gnt_b = reset_n & w_run & w_sel_b;

  assign bus.gnt_a    = w_gnt_a;
  assign bus.gnt_b    = w_gnt_b;
  assign bus.rvalid_a = r_rvalid_a;
  assign bus.rvalid_b = r_rvalid_b;
  assign bus.rdata    = bus.ram_dout;

  always_comb begin
    bus.ram_we   = 1'b0;
    bus.ram_addr = bus.addr_a;
    bus.ram_din  = bus.din_a;
    if (!w_run) begin
      bus.ram_we   = reset_n;
      bus.ram_addr = w_init_addr;
      bus.ram_din  = {DATA_WIDTH{1'b0}};
    end else if (w_gnt_b) begin
      bus.ram_we   = bus.we_b;
      bus.ram_addr = bus.addr_b;
      bus.ram_din  = bus.din_b;
    end else if (w_gnt_a) begin
      bus.ram_we   = bus.we_a;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_b   <= 1'b1;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
    end else begin
      r_rvalid_a <= w_gnt_a & ~bus.we_a;
      r_rvalid_b <= w_gnt_b & ~bus.we_b;
      if (w_gnt_a) begin
        r_last_b <= 1'b0;
      end else if (w_gnt_b) begin
        r_last_b <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_ram_port_arbiter : random traffic vs. reference model, queue scoreboard  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ram_port_arbiter;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;
`ifdef RAM_ARB_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  typedef struct packed {
    logic          busy;
    logic          ga;
    logic          gb;
    logic          we;
    logic          chk_addr;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          rva;
    logic          rvb;
  } cyc_t;

  typedef struct packed {
    logic          cl;
    logic [DW-1:0] d;
  } rd_t;

  bit   clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Single-port RAM with registered read address; contents survive reset.
  logic [DW-1:0] ram [DEPTH];
  logic [AW-1:0] ram_addr_q;
  bit            ram_ready = 1'b0;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
      ram_ready <= 1'b1;
    end else if (bus.ram_we) begin
      ram[bus.ram_addr] <= bus.ram_din;
    end
    ram_addr_q <= bus.ram_addr;
  end
  assign bus.ram_dout = ram[ram_addr_q];

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  bit            last_a;
  int            init_left;
  bit            pend_a, pend_b, hold_a, hold_b;
  cyc_t          cq  [$];
  rd_t           rdq [$];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_cycle(input bit rst, input int pct);
    cyc_t e;
    bit   ga, gb;
    e = '0;
    if (rst) begin
      reset_n     = 1'b0;
      bus.req_a   = 1'b0;
      bus.req_b   = 1'b0;
      last_a      = 1'b0;
      init_left   = INIT_EN ? DEPTH : 0;
      pend_a      = 1'b0;
      pend_b      = 1'b0;
      hold_a      = 1'b0;
      hold_b      = 1'b0;
      rdq.delete();
      e.busy      = INIT_EN;
    end else begin
      reset_n = 1'b1;
      if (!hold_a) begin
        bus.req_a  = ($urandom_range(99) < pct);
        bus.we_a   = 1'($urandom_range(1));
        bus.addr_a = AW'($urandom_range(DEPTH - 1));
        bus.din_a  = DW'($urandom_range(255));
      end
      if (!hold_b) begin
        bus.req_b  = ($urandom_range(99) < pct);
        bus.we_b   = 1'($urandom_range(1));
        bus.addr_b = AW'($urandom_range(DEPTH - 1));
        bus.din_b  = DW'($urandom_range(255));
      end
      e.rva  = pend_a;
      e.rvb  = pend_b;
      pend_a = 1'b0;
      pend_b = 1'b0;
      if (init_left > 0) begin
        e.busy     = 1'b1;
        e.we       = 1'b1;
        e.chk_addr = 1'b1;
        e.addr     = AW'(DEPTH - init_left);
        e.din      = '0;
        ref_mem[e.addr] = '0;
        init_left--;
        hold_a = bus.req_a;
        hold_b = bus.req_b;
      end else begin
        // Lone requester wins; on a tie the one not served last wins.
        ga = bus.req_a && (!bus.req_b || !last_a);
        gb = bus.req_b && !ga;
        e.ga       = ga;
        e.gb       = gb;
        e.chk_addr = ga || gb;
        if (ga || gb) begin
          e.we   = ga ? bus.we_a   : bus.we_b;
          e.addr = ga ? bus.addr_a : bus.addr_b;
          e.din  = ga ? bus.din_a  : bus.din_b;
          if (e.we) ref_mem[e.addr] = e.din;
          else      rdq.push_back({gb, ref_mem[e.addr]});
          pend_a = ga && !e.we;
          pend_b = gb && !e.we;
          last_a = ga;
        end
        hold_a = bus.req_a && !ga;
        hold_b = bus.req_b && !gb;
      end
    end
    cq.push_back(e);
  endtask

  // Monitor: one expected control record per cycle, read data popped on rvalid.
  initial begin
    cyc_t e;
    rd_t  r;
    forever begin
      @(negedge clk);
      if (cq.size() != 0) begin
        e = cq.pop_front();
        check("busy",     bus.busy,     e.busy);
        check("gnt_a",    bus.gnt_a,    e.ga);
        check("gnt_b",    bus.gnt_b,    e.gb);
        check("ram_we",   bus.ram_we,   e.we);
        check("rvalid_a", bus.rvalid_a, e.rva);
        check("rvalid_b", bus.rvalid_b, e.rvb);
        if (e.chk_addr) check("ram_addr", bus.ram_addr, e.addr);
        if (e.we)       check("ram_din",  bus.ram_din,  e.din);
        if (bus.rvalid_a || bus.rvalid_b) begin
          if (rdq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd_unexpected: got rvalid with no read outstanding at %0t", $time);
          end else begin
            r = rdq.pop_front();
            check("rd_client", bus.rvalid_b, r.cl);
            check("rdata",     bus.rdata,    r.d);
          end
        end
      end
    end
  end

  initial begin
    int rst_left = 0;
    bit did_rst  = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    reset_n    = 1'b0;
    bus.req_a  = 1'b0;
    bus.we_a   = 1'b0;
    bus.addr_a = '0;
    bus.din_a  = '0;
    bus.req_b  = 1'b0;
    bus.we_b   = 1'b0;
    bus.addr_b = '0;
    bus.din_b  = '0;
    for (int c = 0; c < 420; c++) begin
      @(posedge clk);
      #1;
      // Second reset lands in the cycle a B read result would appear.
      if (!did_rst && c >= 230 && pend_b) begin
        did_rst  = 1'b1;
        rst_left = 2;
      end
      if (c < 3) begin
        drive_cycle(1'b1, 0);
      end else if (rst_left > 0) begin
        drive_cycle(1'b1, 0);
        rst_left--;
      end else if (c < 150) begin
        drive_cycle(1'b0, 50);
      end else if (c < 200) begin
        drive_cycle(1'b0, 100);
      end else if (c < 215) begin
        drive_cycle(1'b0, 30);
      end else begin
        drive_cycle(1'b0, 70);
      end
    end
    repeat (4) begin
      @(posedge clk);
      #1;
      drive_cycle(1'b0, 0);
    end
    repeat (2) @(negedge clk);
    check("rd_drained", rdq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
